// File: rtl/ace_txn_deallocator.sv
// ace_txn_deallocator
// Return path of the ACE transaction allocator. It tracks every descriptor
// from allocation to completion and then retires it:
//   - RAM regions go back to the address allocator (addr_avail);
//   - descriptors go back to the descriptor allocator (desc_avail).
// RD/WR channels retire in allocation order through an index FIFO. SN
// channels have fixed RAM slots, so they retire the lowest DONE index first.
// Optional feature: define ACE_DEALLOC_ERR_CHK_EN to get the sticky
// err_dbl_alc / err_spur_cmpl flags. Without it both flags are tied to 0.
module ace_txn_deallocator #(
    parameter string CHANNEL_TYPE = "RD",
    parameter int    MAX_DESC     = 16,
    parameter int    IDX_W        = $clog2(MAX_DESC)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                alc_valid,
    input  logic [IDX_W-1:0]    alc_idx,
    input  logic                cmpl_valid,
    input  logic [IDX_W-1:0]    cmpl_idx,
    output logic [MAX_DESC-1:0] desc_avail,
    output logic [MAX_DESC-1:0] addr_avail,
    output logic [IDX_W:0]      outstanding,
    output logic                err_dbl_alc,
    output logic                err_spur_cmpl
);

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } desc_st_e;

    localparam bit IS_SN = (CHANNEL_TYPE == "SN");

    desc_st_e         state_q [MAX_DESC];
    logic             fifo_full;
    logic             alc_ok;
    logic             cmpl_ok;
    logic             retire_vld;
    logic [IDX_W-1:0] retire_idx;

    // Legality is judged against the registered state, so same-cycle events never see each other.
    // An allocation and a completion on the same FREE index therefore make the completion spurious.
    assign alc_ok  = alc_valid && (state_q[alc_idx] == ST_FREE) && !fifo_full;
    assign cmpl_ok = cmpl_valid && (state_q[cmpl_idx] == ST_BUSY);

    // Per-descriptor lifecycle. Retire (DONE), allocate (FREE) and complete (BUSY)
    // each need a different current state, so they never target the same index in one cycle.
    // NOTE: state_q must be reset because FREE is its meaning at start-up; the
    // order FIFO storage further down is left unreset, since only entries between
    // the pointers are ever read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_DESC; i++) begin
                state_q[i] <= ST_FREE;
            end
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // block sees the pre-edge values regardless of evaluation order.
            if (retire_vld) state_q[retire_idx] <= ST_FREE;
            if (alc_ok)     state_q[alc_idx]    <= ST_BUSY;
            if (cmpl_ok)    state_q[cmpl_idx]   <= ST_DONE;
        end
    end

    generate
        if (IS_SN) begin : g_sn
            assign fifo_full = 1'b0;

            // Select the lowest-index DONE descriptor; fixed RAM slots make order irrelevant.
            always_comb begin
                // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
                retire_vld = 1'b0;
                retire_idx = '0;
                for (int i = MAX_DESC - 1; i >= 0; i--) begin
                    if (state_q[i] == ST_DONE) begin
                        retire_vld = 1'b1;
                        retire_idx = IDX_W'(i);
                    end
                end
            end
        end else begin : g_fifo
            logic [IDX_W-1:0] fifo_mem [MAX_DESC];
            logic [IDX_W:0]   wr_ptr_q;
            logic [IDX_W:0]   rd_ptr_q;
            logic             fifo_empty;
            logic [IDX_W-1:0] head_idx;

            // The extra pointer bit tells full from empty when the low bits match.
            assign fifo_empty = (wr_ptr_q == rd_ptr_q);
            assign fifo_full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                                (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
            assign head_idx   = fifo_mem[rd_ptr_q[IDX_W-1:0]];

            // Only the oldest allocation may retire; later DONE entries wait for it.
            assign retire_vld = !fifo_empty && (state_q[head_idx] == ST_DONE);
            assign retire_idx = head_idx;

            // Push on accepted allocation, pop on retire; both may happen together.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    if (alc_ok)     wr_ptr_q <= wr_ptr_q + (IDX_W+1)'(1);
                    if (retire_vld) rd_ptr_q <= rd_ptr_q + (IDX_W+1)'(1);
                end
            end

            // Record allocation order.
            always_ff @(posedge clk) begin
                if (alc_ok) fifo_mem[wr_ptr_q[IDX_W-1:0]] <= alc_idx;
            end
        end
    endgenerate

    // Registered allocator-facing outputs and the in-flight count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            desc_avail  <= '1;
            addr_avail  <= '0;
            outstanding <= '0;
        end else begin
            addr_avail <= '0;
            if (retire_vld) begin
                addr_avail[retire_idx] <= 1'b1;
                desc_avail[retire_idx] <= 1'b1;
            end
            if (alc_ok) desc_avail[alc_idx] <= 1'b0;
            case ({alc_ok, retire_vld})
                2'b10:   outstanding <= outstanding + (IDX_W+1)'(1);
                2'b01:   outstanding <= outstanding - (IDX_W+1)'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef ACE_DEALLOC_ERR_CHK_EN
    // Sticky error flags: set on the first illegal event and held until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_dbl_alc   <= 1'b0;
            err_spur_cmpl <= 1'b0;
        end else begin
            if (alc_valid && !alc_ok)   err_dbl_alc   <= 1'b1;
            if (cmpl_valid && !cmpl_ok) err_spur_cmpl <= 1'b1;
        end
    end
`else
    assign err_dbl_alc   = 1'b0;
    assign err_spur_cmpl = 1'b0;
`endif

endmodule

// File: tb/tb_ace_txn_deallocator.sv
// Testbench for ace_txn_deallocator. Three instances (RD, WR, SN) share one
// stimulus stream. Each is compared every cycle against a behavioural model:
// a queue of allocation order for RD/WR, and a lowest-DONE-first rule for SN.
module tb_ace_txn_deallocator;

    localparam int N   = 16;
    localparam int IW  = 4;
    localparam int S_FREE = 0;
    localparam int S_BUSY = 1;
    localparam int S_DONE = 2;
`ifdef ACE_DEALLOC_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          alc_valid = 1'b0;
    logic [IW-1:0] alc_idx = '0;
    logic          cmpl_valid = 1'b0;
    logic [IW-1:0] cmpl_idx = '0;

    logic [N-1:0]  da [3];
    logic [N-1:0]  aa [3];
    logic [IW:0]   os [3];
    logic          ed [3];
    logic          es [3];

    int n_total = 0;
    int n_bad   = 0;

    // Model: k=0 ordered (RD/WR), k=1 SN.
    int           mst [2][N];
    int           ordq[$];
    logic [N-1:0] m_addr [2];
    bit           m_dbl [2];
    bit           m_spur [2];

    always #5 clk = ~clk;

    ace_txn_deallocator #(.CHANNEL_TYPE("RD"), .MAX_DESC(N)) dut_rd (
        .clk(clk), .resetn(resetn),
        .alc_valid(alc_valid), .alc_idx(alc_idx),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
        .desc_avail(da[0]), .addr_avail(aa[0]), .outstanding(os[0]),
        .err_dbl_alc(ed[0]), .err_spur_cmpl(es[0])
    );

    ace_txn_deallocator #(.CHANNEL_TYPE("WR"), .MAX_DESC(N)) dut_wr (
        .clk(clk), .resetn(resetn),
        .alc_valid(alc_valid), .alc_idx(alc_idx),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
        .desc_avail(da[1]), .addr_avail(aa[1]), .outstanding(os[1]),
        .err_dbl_alc(ed[1]), .err_spur_cmpl(es[1])
    );

    ace_txn_deallocator #(.CHANNEL_TYPE("SN"), .MAX_DESC(N)) dut_sn (
        .clk(clk), .resetn(resetn),
        .alc_valid(alc_valid), .alc_idx(alc_idx),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
        .desc_avail(da[2]), .addr_avail(aa[2]), .outstanding(os[2]),
        .err_dbl_alc(ed[2]), .err_spur_cmpl(es[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) mst[k][i] = S_FREE;
            m_addr[k] = '0;
            m_dbl[k]  = 1'b0;
            m_spur[k] = 1'b0;
        end
        ordq = {};
    endtask

    // Advance one model by one clock, using the inputs currently driven.
    task automatic model_step(input int k);
        int r;
        bit a_ok;
        bit c_ok;
        r = -1;
        if (k == 0) begin
            if (ordq.size() != 0 && mst[0][ordq[0]] == S_DONE) r = ordq[0];
        end else begin
            for (int i = N - 1; i >= 0; i--) if (mst[1][i] == S_DONE) r = i;
        end
        a_ok = alc_valid && (mst[k][alc_idx] == S_FREE);
        c_ok = cmpl_valid && (mst[k][cmpl_idx] == S_BUSY);
        if (alc_valid && !a_ok)  m_dbl[k]  = 1'b1;
        if (cmpl_valid && !c_ok) m_spur[k] = 1'b1;
        m_addr[k] = '0;
        if (r >= 0) begin
            mst[k][r]    = S_FREE;
            m_addr[k][r] = 1'b1;
            if (k == 0) void'(ordq.pop_front());
        end
        if (a_ok) begin
            mst[k][alc_idx] = S_BUSY;
            if (k == 0) ordq.push_back(int'(alc_idx));
        end
        if (c_ok) mst[k][cmpl_idx] = S_DONE;
    endtask

    function automatic logic [N-1:0] exp_da(input int k);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (mst[k][i] == S_FREE);
        return v;
    endfunction

    function automatic logic [IW:0] exp_os(input int k);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) if (mst[k][i] != S_FREE) c++;
        return (IW+1)'(c);
    endfunction

    task automatic compare_all();
        string nm [3];
        int k;
        nm = '{"rd", "wr", "sn"};
        for (int d = 0; d < 3; d++) begin
            k = (d == 2) ? 1 : 0;
            check({nm[d], "_desc_avail"}, 32'(da[d]), 32'(exp_da(k)));
            check({nm[d], "_addr_avail"}, 32'(aa[d]), 32'(m_addr[k]));
            check({nm[d], "_outstanding"}, 32'(os[d]), 32'(exp_os(k)));
            check({nm[d], "_err_dbl"}, 32'(ed[d]), 32'(ERR_EN & m_dbl[k]));
            check({nm[d], "_err_spur"}, 32'(es[d]), 32'(ERR_EN & m_spur[k]));
        end
    endtask

    // Drive one cycle of inputs at a falling edge, then compare after the next rising edge.
    task automatic step(input bit av, input int ai, input bit cv, input int ci);
        alc_valid  = av;
        alc_idx    = IW'(ai);
        cmpl_valid = cv;
        cmpl_idx   = IW'(ci);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0);
    endtask

    task automatic do_reset();
        alc_valid  = 1'b0;
        cmpl_valid = 1'b0;
        resetn     = 1'b0;
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit av;
        bit cv;
        int ai;
        int ci;
        int fl[$];
        int bl[$];

        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        compare_all();
        check("reset_desc_avail", 32'(da[0]), 32'h0000_FFFF);
        check("reset_addr_avail", 32'(aa[0]), 32'h0);
        check("reset_outstanding", 32'(os[0]), 32'h0);

        // Single transaction on RD: allocate 3 at cycle 0, complete at cycle 5.
        step(1'b1, 3, 1'b0, 0);
        check("single_alloc_bit", 32'(da[0][3]), 32'h0);
        idle(4);
        step(1'b0, 0, 1'b1, 3);
        check("single_no_early_pulse", 32'(aa[0]), 32'h0);
        idle(1);
        check("single_pulse", 32'(aa[0]), 32'h0008);
        check("single_desc_back", 32'(da[0][3]), 32'h1);
        // Earliest reuse of the freed index is legal.
        step(1'b1, 3, 1'b0, 0);
        check("reuse_pulse_gone", 32'(aa[0]), 32'h0);
        check("reuse_alloc_bit", 32'(da[0][3]), 32'h0);
        check("reuse_no_err", 32'(ed[0]), 32'h0);
        step(1'b0, 0, 1'b1, 3);
        idle(3);

        // Out-of-order completion on WR.
        step(1'b1, 0, 1'b0, 0);
        step(1'b1, 1, 1'b0, 0);
        step(1'b1, 2, 1'b0, 0);
        step(1'b0, 0, 1'b1, 2);
        check("ooo_hold_a", 32'(aa[1]), 32'h0);
        step(1'b0, 0, 1'b1, 1);
        check("ooo_hold_b", 32'(aa[1]), 32'h0);
        idle(2);
        check("ooo_hold_c", 32'(aa[1]), 32'h0);
        check("ooo_outstanding3", 32'(os[1]), 32'h3);
        step(1'b0, 0, 1'b1, 0);
        idle(1);
        check("ooo_pulse0", 32'(aa[1]), 32'h1);
        idle(1);
        check("ooo_pulse1", 32'(aa[1]), 32'h2);
        idle(1);
        check("ooo_pulse2", 32'(aa[1]), 32'h4);
        check("ooo_outstanding0", 32'(os[1]), 32'h0);
        idle(1);

        // SN channel: completion of 2 retires while 0 and 1 stay busy.
        step(1'b1, 0, 1'b0, 0);
        step(1'b1, 1, 1'b0, 0);
        step(1'b1, 2, 1'b0, 0);
        step(1'b0, 0, 1'b1, 2);
        idle(1);
        check("sn_pulse2", 32'(aa[2]), 32'h4);
        check("sn_busy01", 32'(da[2][1:0]), 32'h0);
        check("sn_outstanding", 32'(os[2]), 32'h2);
        step(1'b0, 0, 1'b1, 0);
        step(1'b0, 0, 1'b1, 1);
        idle(4);

        // Illegal events.
        step(1'b0, 0, 1'b1, 5);
        check("err_spur", 32'(es[0]), 32'(ERR_EN));
        check("err_spur_no_state", 32'(os[0]), 32'h0);
        step(1'b1, 4, 1'b0, 0);
        step(1'b1, 4, 1'b0, 0);
        check("err_dbl", 32'(ed[0]), 32'(ERR_EN));
        check("err_dbl_outstanding", 32'(os[0]), 32'h1);
        // Allocation and completion on the same FREE index.
        step(1'b1, 6, 1'b1, 6);
        check("same_idx_outstanding", 32'(os[0]), 32'h2);

        // Fill all descriptors, then reset asynchronously mid-cycle.
        do_reset();
        for (int i = 0; i < N; i++) step(1'b1, i, 1'b0, 0);
        for (int d = 0; d < 3; d++) begin
            check("fill_outstanding", 32'(os[d]), 32'd16);
            check("fill_desc_avail", 32'(da[d]), 32'h0);
        end
        alc_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check("async_rst_desc", 32'(da[d]), 32'h0000_FFFF);
            check("async_rst_addr", 32'(aa[d]), 32'h0);
            check("async_rst_outstanding", 32'(os[d]), 32'h0);
            check("async_rst_err_dbl", 32'(ed[d]), 32'h0);
            check("async_rst_err_spur", 32'(es[d]), 32'h0);
        end
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        compare_all();

        // Randomised traffic, mostly legal, with occasional illegal events and resets.
        for (int c = 0; c < 2000; c++) begin
            if (c % 500 == 499) do_reset();
            fl = {};
            bl = {};
            for (int i = 0; i < N; i++) begin
                if (mst[0][i] == S_FREE) fl.push_back(i);
                if (mst[0][i] == S_BUSY) bl.push_back(i);
            end
            av = ($urandom_range(0, 99) < 45);
            cv = ($urandom_range(0, 99) < 50);
            if (fl.size() > 0 && $urandom_range(0, 99) < 92)
                ai = fl[$urandom_range(0, fl.size() - 1)];
            else
                ai = int'($urandom_range(0, N - 1));
            if (bl.size() > 0 && $urandom_range(0, 99) < 92)
                ci = bl[$urandom_range(0, bl.size() - 1)];
            else
                ci = int'($urandom_range(0, N - 1));
            step(av, ai, cv, ci);
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ace_txn_deallocator.md
# ace_txn_deallocator

Return path of the ACE transaction allocator. It tracks every allocated descriptor from allocation to completion. It frees RAM regions back to the address allocator strictly in allocation order, and frees descriptors back to the descriptor allocator as each one retires. It sits between the response/completion logic of a channel and the allocator, and drives the allocator's `desc_avail`/`addr_avail` inputs.

## Interface
- `CHANNEL_TYPE`, "RD": "RD", "WR" or "SN". With "SN", RAM slots are fixed per descriptor, so no ordering is enforced.
- `MAX_DESC`, 16: number of descriptors; power of two, at least 2.
- `IDX_W`, derived as `CLOG2(MAX_DESC)`: descriptor index width.

Ports:
- `clk`, in, 1: sole clock.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `alc_valid`, in, 1: one-cycle pulse; descriptor `alc_idx` has been allocated.
- `alc_idx`, in, `IDX_W`: index of the allocated descriptor.
- `cmpl_valid`, in, 1: one-cycle pulse; transaction on descriptor `cmpl_idx` has completed.
- `cmpl_idx`, in, `IDX_W`: index of the completed descriptor.
- `desc_avail`, out, `MAX_DESC`: level signal; bit i high means descriptor i is free.
- `addr_avail`, out, `MAX_DESC`: one-hot, one-cycle pulse; RAM region of descriptor i is released.
- `outstanding`, out, `IDX_W+1`: count of allocated, not yet retired descriptors.
- `err_dbl_alc`, out, 1: sticky; an allocation targeted a busy descriptor.
- `err_spur_cmpl`, out, 1: sticky; a completion targeted a descriptor that was not in flight.

## Operation
Per-descriptor state is one of FREE, BUSY or DONE. All descriptors reset to FREE.

- **Allocation.** `alc_valid` with `alc_idx` FREE:
  - the descriptor moves to BUSY;
  - its `desc_avail` bit is cleared;
  - for RD/WR, the index is pushed into the order FIFO (depth `MAX_DESC`, pointers `IDX_W+1` bits with a wrap bit).
- **Completion.** `cmpl_valid` with `cmpl_idx` BUSY moves the descriptor to DONE.
- **Retire, RD/WR.**
  - Only when the FIFO is non-empty and the head descriptor is DONE.
  - At most one retire per cycle.
  - Retiring pops the FIFO, pulses the head's `addr_avail` bit, sets its `desc_avail` bit and moves it to FREE.
  - A DONE descriptor that is not at the head waits until it reaches the head.
- **Retire, SN.** Any DONE descriptor retires. The lowest DONE index goes first, one per cycle, with the same outputs as RD/WR. No FIFO is instantiated.
- **`outstanding`.** Increments on each accepted allocation and decrements on each retire. When both happen in the same cycle it is unchanged.
- **Illegal events** (`alc_valid` on a non-FREE descriptor, `cmpl_valid` on a non-BUSY descriptor) are ignored. State, FIFO and counters are unchanged. The matching error flag is set when configured (see Configuration).
- **Allocation and completion on the same index in the same cycle.** The descriptor was FREE, so the completion is spurious. The allocation is accepted and the completion is ignored.
- **Allocation and retire in the same cycle.** Push and pop both occur; FIFO full/empty are computed from the post-update pointers.
- **FIFO full.** Cannot occur without an illegal allocation, because the FIFO holds at most `MAX_DESC` entries and each entry is a distinct BUSY/DONE descriptor. A push when full is dropped and counts as a double allocation.

## Timing
- Reset values:
  - `desc_avail` = all ones;
  - `addr_avail` = 0;
  - `outstanding` = 0;
  - both error flags = 0;
  - FIFO empty.
- Allocation: `alc_valid` in cycle N drives the `desc_avail` bit low in N+1.
- Completion of the head descriptor: `cmpl_valid` in cycle N sets DONE in N+1. The retire decision is taken in N+1. The `addr_avail` pulse and the `desc_avail` rise appear in N+2.
- Non-head completion: it retires 1 cycle after the preceding entry retires. Back-to-back DONE entries therefore retire on consecutive cycles.
- Reuse: the earliest re-allocation of a freed index is in cycle N+2, seen by the allocator that cycle. The earliest `desc_avail` fall after re-allocation is N+3.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset asserted mid-operation: all state is cleared asynchronously and any in-flight descriptors are forgotten. Deassertion is synchronised externally.

## Configuration
- Macro: `ACE_DEALLOC_ERR_CHK_EN`.
- When defined:
  - `err_dbl_alc` and `err_spur_cmpl` are set on the first illegal event, one cycle after it;
  - they hold until reset.
- When not defined:
  - both outputs are tied to 0 and the detection logic is removed;
  - illegal events are still ignored as described above.

## Test plan
- **Reset.** Release reset → `desc_avail` = 16'hFFFF, `addr_avail` = 0, `outstanding` = 0.
- **Single transaction (RD).** Allocate 3 at cycle 0 → `desc_avail[3]`=0 at cycle 1. Complete 3 at cycle 5 → `addr_avail` = 16'h0008 for one cycle at cycle 7, and `desc_avail[3]`=1 from cycle 7.
- **Out-of-order completion (WR).**
  - Allocate 0, 1 and 2 on consecutive cycles, then complete 2, then 1; no `addr_avail` pulse occurs.
  - Then complete 0 → pulses 0x1, 0x2 and 0x4 on three consecutive cycles.
  - `outstanding` goes 3→0.
- **SN channel.** Allocate 0, 1 and 2, then complete 2 → `addr_avail` = 0x4 two cycles later, with descriptors 0 and 1 still BUSY.
- **Errors, with the macro defined.**
  - Complete 5 while it is FREE → `err_spur_cmpl`=1 next cycle.
  - Allocate 4 twice → `err_dbl_alc`=1 and `outstanding` = 1.
  - Without the macro, both flags stay 0.
- **Fill and reset.**
  - Allocate all 16 → `outstanding` = 16 and `desc_avail` = 0.
  - Assert `resetn` low mid-cycle → all outputs return to reset values immediately.
